// File: rtl/csi2_lbfr_rd_arbiter_if.sv
// Line-buffer read arbiter bus: line-ready/word-count inputs, header handshake
// and read-enable outputs. tmo_err_o exists only with CSI2_LBFR_TMO_EN.
interface csi2_lbfr_rd_arbiter_if;
   logic [3:0]  line_rdy_i;
   logic [63:0] wc_i;
   logic [3:0]  lbf_lastwd_i;
   logic        tx_ack_i;
   logic [3:0]  hdr_rd_lbfr_en_o;
   logic [15:0] hdr_wdcnt_o;
   logic        tx_req_o;
   logic [1:0]  ch_o;
   logic        busy_o;
`ifdef CSI2_LBFR_TMO_EN
   logic        tmo_err_o;
`endif

   modport slave (
      input  line_rdy_i,
      input  wc_i,
      input  lbf_lastwd_i,
      input  tx_ack_i,
      output hdr_rd_lbfr_en_o,
      output hdr_wdcnt_o,
      output tx_req_o,
      output ch_o,
`ifdef CSI2_LBFR_TMO_EN
      output tmo_err_o,
`endif
      output busy_o
   );

   modport master (
      output line_rdy_i,
      output wc_i,
      output lbf_lastwd_i,
      output tx_ack_i,
      input  hdr_rd_lbfr_en_o,
      input  hdr_wdcnt_o,
      input  tx_req_o,
      input  ch_o,
`ifdef CSI2_LBFR_TMO_EN
      input  tmo_err_o,
`endif
      input  busy_o
   );
endinterface

// File: rtl/csi2_lbfr_rd_arbiter.sv
// Round-robin read arbiter over 4 CSI-2 line buffers (IDLE/HDR/READ/GAP).
// Optional read watchdog enabled by defining CSI2_LBFR_TMO_EN.
module csi2_lbfr_rd_arbiter #(
   parameter int GAP_CYC = 4,
   parameter int TMO_CYC = 65535
) (
   input logic                    tx_clk_i,
   input logic                    rst_n_i,
   csi2_lbfr_rd_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] READ = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   // GAP_CYC of 0 behaves like 1: GAP always lasts at least one cycle
   localparam logic [7:0] GAP_LAST =
      (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

   if (GAP_CYC < 0 || GAP_CYC > 255 ||
       TMO_CYC < 1 || TMO_CYC > 65535) begin : g_param_err
      $error("csi2_lbfr_rd_arbiter: parameter out of range");
   end

   logic [1:0]  state_q, state_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]  ch_q, ch_d;
   logic [15:0] wdcnt_q, wdcnt_d;
   logic [7:0]  gap_q, gap_d;

   logic [1:0]  cand;
   logic [1:0]  gnt_idx;
   logic        gnt_vld;
   logic        lastwd_hit;

`ifdef CSI2_LBFR_TMO_EN
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_err_q, tmo_err_d;
`endif

   // Walk from the highest offset down so the lowest offset wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_ptr_q;
      cand    = '0;
      for (int i = 3; i >= 0; i--) begin
         cand = rr_ptr_q + 2'(i);
         if (bus.line_rdy_i[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign lastwd_hit = bus.lbf_lastwd_i[ch_q];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      ch_d     = ch_q;
      wdcnt_d  = wdcnt_q;
      gap_d    = gap_q;
`ifdef CSI2_LBFR_TMO_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d  = HDR;
               ch_d     = gnt_idx;
               wdcnt_d  = bus.wc_i[{gnt_idx, 4'b0000} +: 16];
               rr_ptr_d = gnt_idx + 2'd1;
            end
         end
         HDR: begin
            if (bus.tx_ack_i) begin
               gap_d   = '0;
               state_d = (wdcnt_q == 16'd0) ? GAP : READ;
`ifdef CSI2_LBFR_TMO_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         READ: begin
            if (lastwd_hit) begin
               state_d = GAP;
               gap_d   = '0;
            end
`ifdef CSI2_LBFR_TMO_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = GAP;
               gap_d     = '0;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
`endif
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge tx_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         ch_q     <= '0;
         wdcnt_q  <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         ch_q     <= ch_d;
         wdcnt_q  <= wdcnt_d;
         gap_q    <= gap_d;
      end
   end

`ifdef CSI2_LBFR_TMO_EN
   always_ff @(posedge tx_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign bus.tmo_err_o = tmo_err_q;
`endif

   // Outputs decode the registered state, so reset clears them at once
   assign bus.tx_req_o         = (state_q == HDR);
   assign bus.busy_o           = (state_q != IDLE);
   assign bus.hdr_rd_lbfr_en_o =
      (state_q == READ) ? (4'b0001 << ch_q) : 4'b0000;
   assign bus.ch_o             = ch_q;
   assign bus.hdr_wdcnt_o      = wdcnt_q;

endmodule
